// File: rtl/sdp_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sdp_fifo_ctrl
//
// Valid/ready stream FIFO built around an external simple dual-port RAM
// (single clock, one-cycle registered read). Upstream words are written
// straight into the RAM. The controller issues RAM reads ahead of demand and
// parks the returned words in a two-entry prefetch buffer, which hides the
// read latency and gives first-word-fall-through output at one word per cycle.
//
// Parameters
//   DWIDTH  data width, must match the RAM
//   DEPTH   RAM entries, power of two, >= 4
//   AWIDTH  RAM address width (derived)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready/in_data   upstream stream (in_ready is registered-state only)
//   out_valid/out_ready/out_data downstream stream, out_data = head word
//   ram_ena/ram_wea/ram_addra/ram_dia   RAM write port
//   ram_enb/ram_addrb/ram_dob           RAM read port (dob valid cycle after enb)
//   count                       words held in RAM + in flight + buffer (registered)
// -----------------------------------------------------------------------------
module sdp_fifo_ctrl #(
  parameter  int DWIDTH = 64,
  parameter  int DEPTH  = 32,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [AWIDTH-1:0] ram_addra,
  output logic [DWIDTH-1:0] ram_dia,
  output logic              ram_enb,
  output logic [AWIDTH-1:0] ram_addrb,
  input  logic [DWIDTH-1:0] ram_dob,
  output logic [AWIDTH+1:0] count
);

  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AWIDTH:0]   wr_ptr, wr_ptr_n;
  logic [AWIDTH:0]   rd_ptr, rd_ptr_n;
  logic [AWIDTH:0]   ram_cnt, ram_cnt_n;
  logic              rd_pend, rd_pend_n;

  // Prefetch buffer: buf_head is the word presented on out_data,
  // buf_tail is the second word when two are held.
  logic [1:0]        buf_cnt, buf_cnt_n;
  logic [DWIDTH-1:0] buf_head, buf_head_n;
  logic [DWIDTH-1:0] buf_tail, buf_tail_n;

  logic [AWIDTH+1:0] count_q, count_n;

  logic              push;
  logic              pop;
  logic              issue;
  logic              capture;
  logic [2:0]        occ;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign ram_cnt  = wr_ptr - rd_ptr;
  assign in_ready = !rst && (ram_cnt != FULL_CNT);
  assign push     = in_valid && in_ready;

  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wr_ptr[AWIDTH-1:0];
  assign ram_dia   = in_data;

  // ---------------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------------
  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf_head;
  assign pop       = out_valid && out_ready;
  assign capture   = rd_pend;

  // Buffer slots committed after this cycle: held words plus the read in
  // flight, minus a word leaving now. A new read is allowed only if its data
  // will still find a free slot when it returns next cycle.
  assign occ   = {1'b0, buf_cnt} + {2'b00, rd_pend};
  assign issue = !rst && (ram_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));

  assign ram_enb   = issue;
  assign ram_addrb = rd_ptr[AWIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign wr_ptr_n  = wr_ptr + {{AWIDTH{1'b0}}, push};
  assign rd_ptr_n  = rd_ptr + {{AWIDTH{1'b0}}, issue};
  assign rd_pend_n = issue;
  assign ram_cnt_n = wr_ptr_n - rd_ptr_n;

  // Two-entry buffer kept as head/tail registers rather than a circular
  // array so that out_data comes straight from a flop. The head only moves
  // on a pop or when a word lands in an empty buffer, which keeps out_data
  // stable under backpressure.
  always_comb begin
    buf_cnt_n  = buf_cnt;
    buf_head_n = buf_head;
    buf_tail_n = buf_tail;
    unique case ({capture, pop})
      2'b01: begin
        if (buf_cnt == 2'd2) begin
          buf_head_n = buf_tail;
        end
        buf_cnt_n = buf_cnt - 2'd1;
      end
      2'b10: begin
        if (buf_cnt == 2'd0) begin
          buf_head_n = ram_dob;
        end else begin
          buf_tail_n = ram_dob;
        end
        buf_cnt_n = buf_cnt + 2'd1;
      end
      2'b11: begin
        if (buf_cnt == 2'd1) begin
          buf_head_n = ram_dob;
        end else begin
          buf_head_n = buf_tail;
          buf_tail_n = ram_dob;
        end
      end
      default: begin
      end
    endcase
  end

  // count reflects the state that will be held after this edge, so it
  // always equals the words accepted and not yet delivered.
  assign count_n = {1'b0, ram_cnt_n}
                 + {{(AWIDTH+1){1'b0}}, rd_pend_n}
                 + {{AWIDTH{1'b0}}, buf_cnt_n};

  assign count = count_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_pend  <= 1'b0;
      buf_cnt  <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      rd_pend  <= rd_pend_n;
      buf_cnt  <= buf_cnt_n;
      buf_head <= buf_head_n;
      buf_tail <= buf_tail_n;
      count_q  <= count_n;
    end
  end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdp_fifo_ctrl
//
// Bench for sdp_fifo_ctrl with DWIDTH = 64, DEPTH = 32, paired with a
// behavioural simple dual-port RAM. A vector table covers reset and the
// single/back-to-back word timing; hand-written sequences cover fill to
// capacity, streaming across pointer wrap, random backpressure and a reset
// taken mid-flight. A queue model holds every accepted word.
// -----------------------------------------------------------------------------
module tb_sdp_fifo_ctrl;

  localparam int DW = 64;
  localparam int DP = 32;
  localparam int AW = $clog2(DP);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dia;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;
  logic [AW+1:0] count;

  always #5 clk = ~clk;

  sdp_fifo_ctrl #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob),
    .count     (count)
  );

  // Simple dual-port RAM, registered read.
  logic [DW-1:0] mem [DP];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  int            n_push;
  bit            popped;
  logic [DW-1:0] popped_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with scoreboard bookkeeping. Inputs are set just after the
  // previous edge; outputs are sampled 1 ns later and count 1 ns after the edge.
  task automatic step();
    #1;
    popped = 1'b0;
    if (ram_ena) chk("no_push_when_not_ready", {63'd0, in_ready}, 64'd1);
    if (out_valid && out_ready) begin
      popped      = 1'b1;
      popped_data = out_data;
      if (q.size() == 0) begin
        chk("pop_from_empty_model", 64'd1, 64'd0);
      end else begin
        chk("out_data_order", out_data, q[0]);
        void'(q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(in_data);
      n_push++;
    end
    @(posedge clk);
    #1;
    chk("count_vs_model", {57'd0, count}, 64'(q.size()));
  endtask

  typedef struct {
    bit          r, iv, ordy;
    logic [63:0] din;
    bit          e_ir, e_ov, c_od;
    logic [63:0] e_od;
    int          e_cnt;
    bit          e_ena, e_enb, c_ab;
    int          e_ab;
  } vec_t;

  function automatic vec_t mkv(bit r, bit iv, bit ordy, logic [63:0] din,
                               bit ir, bit ov, bit cod, logic [63:0] od, int cnt,
                               bit ena, bit enb, bit cab, int ab);
    vec_t v;
    v.r = r; v.iv = iv; v.ordy = ordy; v.din = din;
    v.e_ir = ir; v.e_ov = ov; v.c_od = cod; v.e_od = od; v.e_cnt = cnt;
    v.e_ena = ena; v.e_enb = enb; v.c_ab = cab; v.e_ab = ab;
    return v;
  endfunction

  vec_t vt[16];

  initial begin
    int first_pop, last_pop, n_out;
    bit seen;

    //            r  iv ordy din       ir ov cod od       cnt ena enb cab ab
    vt[0]  = mkv(1, 1, 0, 64'h0,     0, 0, 1, 64'h0,  0, 0, 0, 0, 0);
    vt[1]  = mkv(1, 1, 0, 64'h0,     0, 0, 1, 64'h0,  0, 0, 0, 0, 0);
    vt[2]  = mkv(1, 1, 0, 64'h0,     0, 0, 1, 64'h0,  0, 0, 0, 0, 0);
    vt[3]  = mkv(0, 0, 1, 64'h0,     1, 0, 1, 64'h0,  0, 0, 0, 0, 0);
    vt[4]  = mkv(0, 1, 1, 64'hA5,    1, 0, 0, 64'h0,  0, 1, 0, 0, 0);
    vt[5]  = mkv(0, 0, 1, 64'h0,     1, 0, 0, 64'h0,  1, 0, 1, 1, 0);
    vt[6]  = mkv(0, 0, 1, 64'h0,     1, 0, 0, 64'h0,  1, 0, 0, 0, 0);
    vt[7]  = mkv(0, 0, 1, 64'h0,     1, 1, 1, 64'hA5, 1, 0, 0, 0, 0);
    vt[8]  = mkv(0, 1, 1, 64'h11,    1, 0, 0, 64'h0,  0, 1, 0, 0, 0);
    vt[9]  = mkv(0, 1, 1, 64'h22,    1, 0, 0, 64'h0,  1, 1, 1, 1, 1);
    vt[10] = mkv(0, 0, 1, 64'h0,     1, 0, 0, 64'h0,  2, 0, 1, 1, 2);
    vt[11] = mkv(0, 0, 0, 64'h0,     1, 1, 1, 64'h11, 2, 0, 0, 0, 0);
    vt[12] = mkv(0, 0, 0, 64'h0,     1, 1, 1, 64'h11, 2, 0, 0, 0, 0);
    vt[13] = mkv(0, 0, 1, 64'h0,     1, 1, 1, 64'h11, 2, 0, 0, 0, 0);
    vt[14] = mkv(0, 0, 1, 64'h0,     1, 1, 1, 64'h22, 1, 0, 0, 0, 0);
    vt[15] = mkv(0, 0, 1, 64'h0,     1, 0, 0, 64'h0,  0, 0, 0, 0, 0);

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    #1;

    // Reset, single word and back-to-back timing.
    for (int i = 0; i < 16; i++) begin
      rst = vt[i].r; in_valid = vt[i].iv; out_ready = vt[i].ordy; in_data = vt[i].din;
      #1;
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].e_ir});
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_ov});
      if (vt[i].c_od) chk($sformatf("v%0d_out_data", i), out_data, vt[i].e_od);
      chk($sformatf("v%0d_count", i), {57'd0, count}, 64'(vt[i].e_cnt));
      chk($sformatf("v%0d_ram_ena", i), {63'd0, ram_ena}, {63'd0, vt[i].e_ena});
      chk($sformatf("v%0d_ram_enb", i), {63'd0, ram_enb}, {63'd0, vt[i].e_enb});
      if (vt[i].c_ab) chk($sformatf("v%0d_ram_addrb", i), {59'd0, ram_addrb}, 64'(vt[i].e_ab));
      @(posedge clk);
      #1;
    end

    // Fill to capacity with the output stalled: DEPTH + 2 words accepted.
    q.delete();
    n_push = 0;
    out_ready = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    #1;
    chk("fill_accepted", 64'(n_push), 64'(DP + 2));
    chk("fill_in_ready", {63'd0, in_ready}, 64'd0);
    chk("fill_count", {57'd0, count}, 64'(DP + 2));
    chk("fill_out_valid", {63'd0, out_valid}, 64'd1);
    chk("fill_out_data", out_data, 64'd0);
    step();
    chk("fill_out_data_held", out_data, 64'd0);

    // Drain the filled FIFO; the scoreboard checks order 0..33.
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    chk("fill_drained", 64'(q.size()), 64'd0);
    step();

    // Streaming: 200 words, one output per cycle once the pipe is primed.
    first_pop = -1; last_pop = -1; n_out = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 210; c++) begin
      in_valid = (c < 200);
      in_data  = 64'(c + 64'h1000);
      step();
      if (popped) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        n_out++;
      end
    end
    chk("stream_outputs", 64'(n_out), 64'd200);
    chk("stream_no_gaps", 64'(last_pop - first_pop), 64'd199);
    chk("stream_first_latency", 64'(first_pop), 64'd3);

    // Random backpressure on both sides.
    for (int c = 0; c < 5000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom(), $urandom()};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    chk("random_drained", 64'(q.size()), 64'd0);

    // Reset with 20 words held and a read in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 64'(i + 2000);
      step();
    end
    in_valid = 1'b1; in_data = 64'h3000; out_ready = 1'b1;
    #1;
    chk("mid_read_issued", {63'd0, ram_enb}, 64'd1);
    step();
    chk("mid_count_before_rst", {57'd0, count}, 64'd20);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_count", {57'd0, count}, 64'd0);
    in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (popped) begin
        seen = 1'b1;
        chk("mid_first_out", popped_data, 64'h77);
      end
    end
    if (!seen) chk("mid_first_out_timeout", 64'd0, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
